// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions.
// Opcodes recognised by the hazard logic and the stall FSM state type.
package mips_pkg;

    localparam logic [5:0] OP_LD  = 6'b010100;
    localparam logic [5:0] OP_JMP = 6'b011110;
    localparam logic [5:0] OP_HLT = 6'b010001;

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        RELEASE,
        HALT
    } stall_state_t;

endpackage

// File: rtl/stall_control_block.sv
// Decode-stage hazard stall generator for loads, jumps and halt.
// Stall is a Mealy output; stall_pm is the registered copy.
module stall_control_block
    import mips_pkg::*;
#(
    parameter int unsigned LD_STALL_CYCLES  = 1,
    parameter int unsigned JMP_STALL_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    output logic       stall,
    output logic       stall_pm
);

    localparam logic [3:0] LD_CNT  = 4'(LD_STALL_CYCLES - 1);
    localparam logic [3:0] JMP_CNT = 4'(JMP_STALL_CYCLES - 1);

    stall_state_t state;
    stall_state_t state_n;
    logic [3:0]   cnt;
    logic [3:0]   cnt_n;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            stall_pm <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            stall_pm <= stall;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        stall   = 1'b0;
        unique case (state)
            IDLE: begin
                if (op == OP_HLT) begin
                    stall   = 1'b1;
                    state_n = HALT;
                end else if (op == OP_LD) begin
                    stall   = 1'b1;
                    cnt_n   = LD_CNT;
                    state_n = (LD_CNT == 4'd0) ? RELEASE : STALL;
                end else if (op == OP_JMP) begin
                    stall   = 1'b1;
                    cnt_n   = JMP_CNT;
                    state_n = (JMP_CNT == 4'd0) ? RELEASE : STALL;
                end
            end
            STALL: begin
                stall = 1'b1;
                cnt_n = cnt - 4'd1;
                if (op == OP_HLT) begin
                    state_n = HALT;
                end else if (cnt <= 4'd1) begin
                    state_n = RELEASE;
                end
            end
            // Held instruction proceeds; only halt may re-stall here
            RELEASE: begin
                if (op == OP_HLT) begin
                    stall   = 1'b1;
                    state_n = HALT;
                end else begin
                    state_n = IDLE;
                end
            end
            HALT: begin
                stall = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_stall_control_block.sv
// Testbench for stall_control_block: directed table, corner sequences,
// and randomized ops against a cycle-occupancy reference model.
module tb_stall_control_block;
    import mips_pkg::*;

    localparam int LD_C  = 1;
    localparam int JMP_C = 2;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       stall;
    logic       stall_pm;

    stall_control_block #(
        .LD_STALL_CYCLES (LD_C),
        .JMP_STALL_CYCLES(JMP_C)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .op      (op),
        .stall   (stall),
        .stall_pm(stall_pm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] op;
        logic       st;
        logic       pm;
    } vec_t;

    vec_t tbl[$];
    int   pass_cnt = 0;
    int   total    = 0;

    // Reference model: halted flag plus cycles left in decode
    // for the current hazard instruction (last one is release).
    bit m_halt = 0;
    int m_left = 0;
    bit m_pm   = 0;

    function automatic bit m_stall(input logic [5:0] o);
        if (m_halt) return 1'b1;
        if (o == OP_HLT) return 1'b1;
        if (m_left > 0) return m_left > 1;
        if (o == OP_LD || o == OP_JMP) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_clock(input logic [5:0] o, input bit s);
        m_pm = s;
        if (m_halt) begin
        end else if (o == OP_HLT) begin
            m_halt = 1;
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
        end else if (o == OP_LD) begin
            m_left = LD_C;
        end else if (o == OP_JMP) begin
            m_left = JMP_C;
        end
    endtask

    task automatic m_reset();
        m_halt = 0;
        m_left = 0;
        m_pm   = 0;
    endtask

    task automatic chk(input string nm, input logic act, input logic exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    endtask

    // Apply one cycle; compare against given values or the model.
    task automatic run(input logic [5:0] o, input bit use_exp,
                       input logic es, input logic ep, input string nm);
        bit s;
        op = o;
        @(negedge clk);
        s = m_stall(o);
        if (use_exp) begin
            chk({nm, " stall"}, stall, es);
            chk({nm, " stall_pm"}, stall_pm, ep);
        end else begin
            chk({nm, " stall"}, stall, s);
            chk({nm, " stall_pm"}, stall_pm, m_pm);
        end
        @(posedge clk);
        m_clock(o, s);
        #1;
    endtask

    task automatic pulse_reset(input string nm);
        op = 6'd0;
        reset = 1'b0;
        #1;
        chk({nm, " rst stall_pm"}, stall_pm, 1'b0);
        chk({nm, " rst stall"}, stall, 1'b0);
        #1;
        reset = 1'b1;
        m_reset();
    endtask

    initial begin
        reset = 1'b1;
        op    = 6'd0;
        #2 reset = 1'b0;
        #6 reset = 1'b1;
        @(negedge clk);
        chk("reset stall", stall, 1'b0);
        chk("reset stall_pm", stall_pm, 1'b0);
        @(posedge clk);
        #1;

        // load, no retrigger
        tbl.push_back('{OP_LD, 1'b1, 1'b0});
        tbl.push_back('{OP_LD, 1'b0, 1'b1});
        tbl.push_back('{6'd0, 1'b0, 1'b0});
        // jump
        tbl.push_back('{OP_JMP, 1'b1, 1'b0});
        tbl.push_back('{OP_JMP, 1'b1, 1'b1});
        tbl.push_back('{OP_JMP, 1'b0, 1'b1});
        tbl.push_back('{6'd0, 1'b0, 1'b0});
        // non-hazard
        tbl.push_back('{6'd0, 1'b0, 1'b0});
        tbl.push_back('{6'h3f, 1'b0, 1'b0});
        tbl.push_back('{6'b010101, 1'b0, 1'b0});
        tbl.push_back('{6'd0, 1'b0, 1'b0});
        tbl.push_back('{6'h3f, 1'b0, 1'b0});
        // back-to-back loads
        tbl.push_back('{OP_LD, 1'b1, 1'b0});
        tbl.push_back('{OP_LD, 1'b0, 1'b1});
        tbl.push_back('{OP_LD, 1'b1, 1'b0});
        tbl.push_back('{6'd0, 1'b0, 1'b1});
        tbl.push_back('{6'd0, 1'b0, 1'b0});
        // halt from idle
        tbl.push_back('{OP_HLT, 1'b1, 1'b0});
        tbl.push_back('{6'd0, 1'b1, 1'b1});
        tbl.push_back('{6'd0, 1'b1, 1'b1});
        tbl.push_back('{OP_LD, 1'b1, 1'b1});

        foreach (tbl[i]) run(tbl[i].op, 1'b1, tbl[i].st, tbl[i].pm, $sformatf("tbl%0d", i));

        pulse_reset("halt");
        run(6'd0, 1'b1, 1'b0, 1'b0, "after halt rst");

        // halt while stalling on a jump
        run(OP_JMP, 1'b1, 1'b1, 1'b0, "jmp");
        run(OP_HLT, 1'b1, 1'b1, 1'b1, "hlt in stall");
        run(6'd0, 1'b1, 1'b1, 1'b1, "halted");
        pulse_reset("halt2");

        // halt in release cycle
        run(OP_LD, 1'b1, 1'b1, 1'b0, "ld");
        run(OP_HLT, 1'b1, 1'b1, 1'b1, "hlt in release");
        run(6'd0, 1'b1, 1'b1, 1'b1, "halted2");
        pulse_reset("halt3");

        // reset mid-stall leaves no residual stall
        run(OP_JMP, 1'b1, 1'b1, 1'b0, "jmp2");
        pulse_reset("midstall");
        run(6'd0, 1'b1, 1'b0, 1'b0, "after midstall");
        run(6'd0, 1'b1, 1'b0, 1'b0, "after midstall2");

        m_reset();
        for (int i = 0; i < 600; i++) begin
            int r;
            logic [5:0] o;
            r = $urandom_range(0, 15);
            if (r < 4) o = OP_LD;
            else if (r < 8) o = OP_JMP;
            else if (r == 8) o = OP_HLT;
            else o = 6'($urandom);
            run(o, 1'b0, 1'b0, 1'b0, $sformatf("rand%0d", i));
            if ($urandom_range(0, 19) == 0) pulse_reset("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
